// File: rtl/mysystem_mm_pkg.sv
// Shared definitions for the mysystem memory-mapped stream blocks.
//   MM_ADDR_W    : RAM word address width
//   MM_DATA_W    : RAM word width
//   MM_MEM_WORDS : words in the on-chip RAM (addresses wrap at this bound)
//   rd_state_e   : stream reader FSM states
package mysystem_mm_pkg;

    localparam int unsigned MM_ADDR_W    = 18;
    localparam int unsigned MM_DATA_W    = 16;
    localparam int unsigned MM_MEM_WORDS = 180000;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/mysystem_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (clears pointers, count and storage)
//   push_i      : write push_data_i this cycle (caller guarantees not full)
//   push_data_i : write data
//   pop_i       : consume head this cycle (ignored when empty)
//   pop_data_o  : head entry, valid while valid_o=1
//   valid_o     : FIFO not empty
//   count_o     : number of stored entries
// Depth must be a power of two so the pointers wrap naturally.
module mysystem_sync_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 16,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    always_comb begin
        valid_o    = (count_q != '0);
        do_pop     = pop_i & valid_o;
        pop_data_o = mem_q[rd_ptr_q];
        count_o    = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/mysystem_mm_stream_reader.sv
// Avalon-MM read master that streams a block of RAM words out as Avalon-ST.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : 1-cycle pulse, accepted only while busy=0
//   base_addr, length     : first word address and word count, sampled on accepted start
//   busy, done            : transfer in progress / 1-cycle completion pulse
//   avm_*                 : read master toward the fixed-latency on-chip RAM
//   st_data/valid/ready/last : output stream, FIFO head (first-word-fall-through)
// Optional feature macro STREAM_CHECKSUM_EN adds checksum[DATA_W-1:0] (mod-2^16 sum of
// transferred beats) and checksum_valid (equal to done).
module mysystem_mm_stream_reader
    import mysystem_mm_pkg::*;
#(
    parameter int unsigned ADDR_W       = MM_ADDR_W,
    parameter int unsigned DATA_W       = MM_DATA_W,
    parameter int unsigned MEM_WORDS    = MM_MEM_WORDS,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [1:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
`ifdef STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum,
    output logic              checksum_valid
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    rd_state_e               state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    cs_q;
    logic [ADDR_W-1:0]       avm_address_q;
    logic [ADDR_W-1:0]       next_addr_q;
    logic [ADDR_W-1:0]       issue_cnt_q;
    logic [ADDR_W-1:0]       beat_cnt_q;
    logic [ADDR_W-1:0]       len_q;
    // One flag per outstanding read; the oldest flag marks readdata valid this cycle.
    logic [READ_LATENCY-1:0] sr_q;
    logic [READ_LATENCY-1:0] sr_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_valid;
    logic [CntW-1:0]         fifo_count;
    logic                    credit_ok;
    logic                    last_beat;
    logic                    start_accept;
    int unsigned             occ_next;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    mysystem_sync_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DATA_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i (avm_readdata),
        .pop_i       (pop),
        .pop_data_o  (st_data),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    always_comb begin
        push         = sr_q[READ_LATENCY-1];
        pop          = fifo_valid & st_ready;
        sr_d         = READ_LATENCY'({sr_q, cs_q});
        // Occupancy after this edge (FIFO plus reads still in the RAM pipeline); a new
        // strobe is registered only if its word is guaranteed a FIFO slot.
        occ_next     = 32'(fifo_count) + 32'(push) + 32'($countones(sr_d)) - 32'(pop);
        credit_ok    = (occ_next < FIFO_DEPTH);
        last_beat    = pop && (beat_cnt_q == len_q - ADDR_W'(1));
        start_accept = start & ~busy_q;

        busy           = busy_q;
        done           = done_q;
        avm_address    = avm_address_q;
        avm_chipselect = cs_q;
        avm_write      = 1'b0;
        avm_byteenable = 2'b11;
        avm_clken      = 1'b1;
        st_valid       = fifo_valid;
        st_last        = fifo_valid && (beat_cnt_q == len_q - ADDR_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RD_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cs_q          <= 1'b0;
            avm_address_q <= '0;
            next_addr_q   <= '0;
            issue_cnt_q   <= '0;
            beat_cnt_q    <= '0;
            len_q         <= '0;
            sr_q          <= '0;
        end else begin
            done_q <= 1'b0;
            cs_q   <= 1'b0;
            sr_q   <= sr_d;
            if (pop) begin
                beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
            end
            unique case (state_q)
                RD_IDLE, RD_DONE: begin
                    state_q <= RD_IDLE;
                    if (start_accept) begin
                        len_q      <= length;
                        beat_cnt_q <= '0;
                        if (length == '0) begin
                            state_q <= RD_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // FIFO is empty here, so the first strobe needs no credit check.
                            busy_q        <= 1'b1;
                            cs_q          <= 1'b1;
                            avm_address_q <= base_addr;
                            next_addr_q   <= wrap_inc(base_addr);
                            issue_cnt_q   <= ADDR_W'(1);
                            state_q       <= (length == ADDR_W'(1)) ? RD_DRAIN : RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (credit_ok) begin
                        cs_q          <= 1'b1;
                        avm_address_q <= next_addr_q;
                        next_addr_q   <= wrap_inc(next_addr_q);
                        issue_cnt_q   <= issue_cnt_q + ADDR_W'(1);
                        if (issue_cnt_q + ADDR_W'(1) == len_q) begin
                            state_q <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (last_beat) begin
                        state_q <= RD_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

`ifdef STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + st_data;
        end
    end

    always_comb begin
        checksum       = checksum_q;
        checksum_valid = done_q;
    end
`else
    // Checksum logic not built.
`endif

endmodule
